// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: TX state encoding, framing constants and a
// byte-wide reflected CRC32 step used by the MII transmitter and RGMII receiver.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_e;

  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // LSB-first bit-serial update unrolled over one byte
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC32 accumulator; init has priority over en. Output is the raw
// register (not complemented) so receivers can compare against CRC_RESIDUE.
module eth_crc32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  d_i,
  output logic [31:0] crc_o
);
  import eth_pkg::*;

  logic [31:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      crc_q <= CRC_INIT;
    else if (init_i) crc_q <= CRC_INIT;
    else if (en_i)   crc_q <= crc32_byte(crc_q, d_i);
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/eth_mii_tx.sv
// Nibble-wide Ethernet MII transmitter: preamble/SFD, payload, zero pad,
// CRC32 FCS and inter-frame gap, with all PHY and handshake outputs registered.
module eth_mii_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_LEN      = 60,
  parameter bit PAD_EN       = 1'b1,
  parameter int IFG_BYTES    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       sop_i,
  input  logic       eop_i,
  output logic       ready_o,
  output logic       pin_tx_en_o,
  output logic [3:0] pin_tx_data_o,
  output logic       busy_o,
  output logic       underrun_o
);
  import eth_pkg::*;

  localparam logic [7:0]  PRE_LAST  = 8'(2 * PREAMBLE_LEN + 1);
  // The IDLE accept cycle is the final gap clock, so a held-valid source
  // sees exactly 2*IFG_BYTES idle clocks between frames.
  localparam logic [7:0]  IFG_LAST  = 8'(2 * IFG_BYTES - 2);
  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);

  state_e      state_q;
  logic        phase_q, eop_q, ready_q, tx_en_q, busy_q, underrun_q;
  logic [7:0]  byte_q, nib_q;
  logic [3:0]  txd_q;
  logic [10:0] bcnt_q;
  logic [31:0] fcs_q, crc, fcs_good;
  logic        crc_en, need_pad;
  logic [7:0]  crc_d;

  // Each byte enters the CRC while its low nibble is on the wire, so the
  // CRC is final by the time the last high nibble is sent.
  assign crc_en   = (state_q == ST_DATA || state_q == ST_PAD) && !phase_q;
  assign crc_d    = (state_q == ST_PAD) ? 8'h00 : byte_q;
  assign fcs_good = ~crc;
  assign need_pad = PAD_EN && (bcnt_q < MIN_LEN_C);

  eth_crc32 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init_i(state_q == ST_IDLE),
    .en_i  (crc_en),
    .d_i   (crc_d),
    .crc_o (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      eop_q      <= 1'b0;
      ready_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      byte_q     <= '0;
      nib_q      <= '0;
      txd_q      <= '0;
      bcnt_q     <= '0;
      fcs_q      <= '0;
    end else begin
      underrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (valid_i && ready_q && sop_i) begin
            byte_q  <= data_i;
            eop_q   <= eop_i;
            nib_q   <= '0;
            bcnt_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            tx_en_q <= 1'b1;
            txd_q   <= PRE_NIB;
            state_q <= ST_PRE;
          end
        end
        ST_PRE: begin
          nib_q <= nib_q + 8'd1;
          txd_q <= (nib_q == PRE_LAST - 8'd1) ? SFD_NIB : PRE_NIB;
          if (nib_q == PRE_LAST) begin
            phase_q <= 1'b0;
            txd_q   <= byte_q[3:0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            txd_q   <= byte_q[7:4];
            ready_q <= ~eop_q;
            if (bcnt_q != MIN_LEN_C) bcnt_q <= bcnt_q + 11'd1;
          end else begin
            ready_q <= 1'b0;
            if (!eop_q) begin
              if (valid_i) begin
                byte_q <= data_i;
                eop_q  <= eop_i;
                txd_q  <= data_i[3:0];
              end else begin
                // Starved: close the frame with a deliberately wrong FCS
                underrun_q <= 1'b1;
                nib_q      <= '0;
                txd_q      <= crc[3:0];
                fcs_q      <= crc >> 4;
                state_q    <= ST_FCS;
              end
            end else if (need_pad) begin
              txd_q   <= 4'h0;
              state_q <= ST_PAD;
            end else begin
              nib_q   <= '0;
              txd_q   <= fcs_good[3:0];
              fcs_q   <= fcs_good >> 4;
              state_q <= ST_FCS;
            end
          end
        end
        ST_PAD: begin
          phase_q <= ~phase_q;
          txd_q   <= 4'h0;
          if (!phase_q) begin
            if (bcnt_q != MIN_LEN_C) bcnt_q <= bcnt_q + 11'd1;
          end else if (!need_pad) begin
            nib_q   <= '0;
            txd_q   <= fcs_good[3:0];
            fcs_q   <= fcs_good >> 4;
            state_q <= ST_FCS;
          end
        end
        ST_FCS: begin
          nib_q <= nib_q + 8'd1;
          txd_q <= fcs_q[3:0];
          fcs_q <= fcs_q >> 4;
          if (nib_q == 8'd7) begin
            nib_q   <= '0;
            tx_en_q <= 1'b0;
            txd_q   <= 4'h0;
            state_q <= ST_IFG;
          end
        end
        ST_IFG: begin
          nib_q <= nib_q + 8'd1;
          if (nib_q == IFG_LAST) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign pin_tx_en_o   = tx_en_q;
  assign pin_tx_data_o = txd_q;
  assign busy_o        = busy_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_eth_mii_tx.sv
// Bench for eth_mii_tx: a padding and a non-padding instance share the source;
// PHY nibble streams are compared against a frame-level reference model.
module tb_eth_mii_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data = '0;
  logic       valid = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [1:0] rdy, ten, busy, urun;
  logic [3:0] txd0, txd1;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, urun_cnt = 0, idle_viol = 0;
  logic prev0 = 1'b0;
  logic [3:0] cap0[$], cap1[$], exp_q[$], tmp_q[$];
  logic [7:0] fr_q[$], fr2_q[$];
  int rise0[$], fall0[$], acc0[$];

  always #5 clk = ~clk;

  eth_mii_tx #(.PAD_EN(1'b1)) u_pad (
    .clk(clk), .rst_n(rst_n), .data_i(data), .valid_i(valid), .sop_i(sop), .eop_i(eop),
    .ready_o(rdy[0]), .pin_tx_en_o(ten[0]), .pin_tx_data_o(txd0), .busy_o(busy[0]),
    .underrun_o(urun[0]));

  eth_mii_tx #(.PAD_EN(1'b0)) u_nopad (
    .clk(clk), .rst_n(rst_n), .data_i(data), .valid_i(valid), .sop_i(sop), .eop_i(eop),
    .ready_o(rdy[1]), .pin_tx_en_o(ten[1]), .pin_tx_data_o(txd1), .busy_o(busy[1]),
    .underrun_o(urun[1]));

  always @(posedge clk) begin
    if (rst_n && valid && sop && rdy[0]) acc0.push_back(cyc);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ten[0]) cap0.push_back(txd0);
    if (ten[1]) cap1.push_back(txd1);
    if (ten[0] && !prev0) rise0.push_back(cyc);
    if (!ten[0] && prev0) fall0.push_back(cyc);
    prev0     <= ten[0];
    urun_cnt  <= urun_cnt + int'(urun[0]);
    idle_viol <= idle_viol + int'(!ten[0] && txd0 != 4'h0) + int'(!ten[1] && txd1 != 4'h0);
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_of(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[k]) begin
      c ^= {24'h0, b[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Wire image of one frame: preamble+SFD, bytes low nibble first, optional
  // zero pad to 60 bytes, FCS = ~crc (or raw crc for a poisoned frame).
  task automatic build_exp(input logic [7:0] fr[$], input bit pad, input bit bad);
    logic [7:0]  b[$];
    logic [31:0] f;
    b = fr;
    if (pad) while (b.size() < 60) b.push_back(8'h00);
    exp_q.delete();
    for (int k = 0; k < 15; k++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    foreach (b[k]) begin
      exp_q.push_back(b[k][3:0]);
      exp_q.push_back(b[k][7:4]);
    end
    f = crc_of(b);
    if (!bad) f = ~f;
    for (int k = 0; k < 8; k++) exp_q.push_back(f[4*k +: 4]);
  endtask

  task automatic cmp_stream(input string tag, input logic [3:0] obs[$]);
    int bad_idx = -1;
    chk({tag, "_len"}, obs.size(), exp_q.size());
    for (int k = 0; k < obs.size() && k < exp_q.size(); k++)
      if (obs[k] !== exp_q[k] && bad_idx < 0) bad_idx = k;
    chk({tag, "_first_bad_nibble"}, bad_idx, -1);
  endtask

  task automatic rand_frame(input int len);
    fr_q.delete();
    for (int k = 0; k < len; k++) fr_q.push_back(8'($urandom));
  endtask

  // Drive bytes whenever instance `sel` is ready; optionally withhold valid
  // on the ready cycle that asks for byte gap_at, ending the frame there.
  task automatic send(input logic [7:0] fr[$], input int sel, input int gap_at, input bit keep);
    int  i = 0, guard = 0;
    logic r;
    while (i < fr.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
      r = rdy[sel];
      if (i == gap_at && r) begin
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
        @(posedge clk);
        break;
      end
      valid = 1'b1; data = fr[i]; sop = (i == 0); eop = (i == fr.size() - 1);
      @(posedge clk);
      if (r) i++;
    end
    chk("send_bounded", guard < 4000, 1);
    if (!keep) begin
      @(negedge clk);
      valid = 1'b0; sop = 1'b0; eop = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin @(negedge clk); g++; end while (busy != 2'b00 && g < 3000);
    repeat (2) @(negedge clk);
    chk("idle_reached", g < 3000, 1);
  endtask

  task automatic clear_caps();
    cap0.delete(); cap1.delete(); rise0.delete(); fall0.delete(); acc0.delete();
  endtask

  initial begin
    logic [31:0] w, good;
    int u0, bad_seen;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {ten, busy, urun, rdy, txd0, txd1}, '0);
    rst_n = 1'b1;
    #1 chk("rst_ready_low_before_clk", rdy, 2'b00);
    @(posedge clk); #1;
    chk("rst_ready_after_1clk", rdy, 2'b11);

    // Non-padding reference vector "123456789"
    clear_caps();
    fr_q.delete();
    for (int k = 0; k < 9; k++) fr_q.push_back(8'h31 + 8'(k));
    send(fr_q, 1, -1, 0);
    wait_idle();
    build_exp(fr_q, 0, 0);
    cmp_stream("crc_vec_nopad", cap1);
    w = '0;
    if (cap1.size() >= 8) for (int k = 0; k < 8; k++) w[4*k +: 4] = cap1[cap1.size() - 8 + k];
    chk("crc_vec_fcs", w, 32'hCBF43926);
    build_exp(fr_q, 1, 0);
    cmp_stream("crc_vec_pad", cap0);

    // Short frame padded to 60 bytes
    clear_caps();
    rand_frame(14);
    send(fr_q, 0, -1, 0);
    wait_idle();
    chk("pad_txen_clks", cap0.size(), 144);
    build_exp(fr_q, 1, 0);
    cmp_stream("pad14", cap0);
    build_exp(fr_q, 0, 0);
    cmp_stream("nopad14", cap1);

    // Back-to-back 64-byte frames with valid held high
    clear_caps();
    rand_frame(64);
    fr2_q = fr_q;
    rand_frame(64);
    send(fr2_q, 0, -1, 1);
    send(fr_q, 0, -1, 0);
    wait_idle();
    build_exp(fr2_q, 1, 0);
    tmp_q = exp_q;
    build_exp(fr_q, 1, 0);
    exp_q = {tmp_q, exp_q};
    cmp_stream("b2b", cap0);
    chk("b2b_edges", {8'(rise0.size()), 8'(fall0.size()), 8'(acc0.size())}, 24'h020202);
    if (rise0.size() == 2 && fall0.size() == 2 && acc0.size() == 2) begin
      chk("b2b_gap_clks", rise0[1] - fall0[0], 24);
      chk("b2b_latency0", rise0[0] - acc0[0], 1);
      chk("b2b_latency1", rise0[1] - acc0[1], 1);
    end

    // Underrun at byte 20
    clear_caps();
    u0 = urun_cnt;
    rand_frame(64);
    send(fr_q, 0, 20, 0);
    wait_idle();
    chk("underrun_pulses", urun_cnt - u0, 1);
    build_exp(fr_q[0:19], 0, 1);
    cmp_stream("underrun_stream", cap0);
    good = ~crc_of(fr_q[0:19]);
    w = '0;
    if (cap0.size() >= 8) for (int k = 0; k < 8; k++) w[4*k +: 4] = cap0[cap0.size() - 8 + k];
    chk("underrun_fcs_bad", w != good, 1);

    // Reset asserted during FCS
    clear_caps();
    rand_frame(14);
    send(fr_q, 0, -1, 0);
    u0 = 0;
    do begin @(negedge clk); #1; u0++; end while (cap0.size() < 140 && u0 < 2000);
    chk("fcs_reached", cap0.size(), 140);
    rst_n = 1'b0;
    #1 chk("rst_mid_fcs_async", {ten, busy, txd0}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_mid_ready_low", rdy, 2'b00);
    @(posedge clk); #1;
    chk("rst_mid_ready_high", rdy, 2'b11);
    clear_caps();
    rand_frame(70);
    send(fr_q, 0, -1, 0);
    wait_idle();
    build_exp(fr_q, 1, 0);
    cmp_stream("post_reset", cap0);

    // Headless bytes in IDLE are swallowed
    clear_caps();
    bad_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bad_seen += int'(ten != 2'b00 || busy != 2'b00);
      valid = 1'b1; sop = 1'b0; eop = 1'b0; data = 8'($urandom);
    end
    @(negedge clk);
    bad_seen += int'(ten != 2'b00 || busy != 2'b00);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    bad_seen += int'(ten != 2'b00 || busy != 2'b00);
    chk("nosop_ignored", bad_seen, 0);
    chk("nosop_no_tx", cap0.size() + cap1.size(), 0);

    // Random frame lengths around the pad threshold
    for (int t = 0; t < 6; t++) begin
      clear_caps();
      rand_frame($urandom_range(1, 100));
      send(fr_q, 0, -1, 0);
      wait_idle();
      build_exp(fr_q, 1, 0);
      cmp_stream($sformatf("rand%0d_pad", t), cap0);
      build_exp(fr_q, 0, 0);
      cmp_stream($sformatf("rand%0d_nopad", t), cap1);
    end

    chk("data_zero_when_idle", idle_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
